// File: rtl/arb_pkg.sv
// Shared constants for the arbiter request feeder: port identifiers and default sizing.
package arb_pkg;

   localparam logic PORT_1 = 1'b0;
   localparam logic PORT_2 = 1'b1;

   localparam int ARB_DATA_W = 32;
   localparam int ARB_DEPTH  = 4;

endpackage

// File: rtl/req_fifo.sv
// Per-port circular FIFO. The head is combinational from storage (zero read latency).
// A push is refused while full, even if a pop happens in the same cycle. A pop is refused while empty.
module req_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push_i,
   input  logic [DATA_W-1:0]      push_dat_i,
   input  logic                   pop_i,
   output logic [DATA_W-1:0]      head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              do_push, do_pop;

   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = cnt_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Pointers wrap naturally; the count alone separates full from empty.
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

endmodule

// File: rtl/arb_req_queue.sv
// Two-port request queue feeding a two-requester arbiter. req_x follows a push by one cycle.
// A granted head is presented combinationally and holds until out_ready; port 1 wins a double grant.
module arb_req_queue
   import arb_pkg::*;
#(
   parameter int DATA_W = ARB_DATA_W,
   parameter int DEPTH  = ARB_DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in1_valid,
   output logic              in1_ready,
   input  logic [DATA_W-1:0] in1_data,
   input  logic              in2_valid,
   output logic              in2_ready,
   input  logic [DATA_W-1:0] in2_data,
   output logic              req_1,
   output logic              req_2,
   input  logic              grant_1,
   input  logic              grant_2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_port,
   output logic              grant_err
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [DATA_W-1:0] head_1, head_2;
   logic [CNT_W-1:0]  count_1, count_2;
   logic              full_1, full_2, empty_1, empty_2;
   logic              push_1, push_2, pop_1, pop_2;
   logic              sel_1, sel_2;
   logic              grant_err_q, grant_err_d;

   assign in1_ready = ~full_1;
   assign in2_ready = ~full_2;
   assign push_1    = in1_valid & in1_ready;
   assign push_2    = in2_valid & in2_ready;

   // Port 2 is only presented when port 1 is not; a stale grant on an empty queue selects nothing.
   assign sel_1 = grant_1 & ~empty_1;
   assign sel_2 = grant_2 & ~empty_2 & ~sel_1;
   assign pop_1 = sel_1 & out_ready;
   assign pop_2 = sel_2 & out_ready;

   assign req_1 = (count_1 > ONE) | ((count_1 == ONE) & ~pop_1);
   assign req_2 = (count_2 > ONE) | ((count_2 == ONE) & ~pop_2);

   assign out_valid = sel_1 | sel_2;
   assign out_port  = sel_2 ? PORT_2 : PORT_1;
   assign out_data  = sel_1 ? head_1 : (sel_2 ? head_2 : '0);

   assign grant_err_d = grant_err_q | (grant_1 & grant_2);
   assign grant_err   = grant_err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_err_q <= 1'b0;
      end else begin
         grant_err_q <= grant_err_d;
      end
   end

   req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .push_i    (push_1),
      .push_dat_i(in1_data),
      .pop_i     (pop_1),
      .head_o    (head_1),
      .count_o   (count_1),
      .full_o    (full_1),
      .empty_o   (empty_1)
   );

   req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_2 (
      .clk       (clk),
      .reset_n   (reset_n),
      .push_i    (push_2),
      .push_dat_i(in2_data),
      .pop_i     (pop_2),
      .head_o    (head_2),
      .count_o   (count_2),
      .full_o    (full_2),
      .empty_o   (empty_2)
   );

endmodule

// File: tb/tb_arb_req_queue.sv
// Bench for arb_req_queue: table-driven vectors, corner-case sequences, and a queue-based reference model under random stimulus.
module tb_arb_req_queue;
   localparam int DW = 32;
   localparam int DP = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in1_valid, in2_valid, grant_1, grant_2, out_ready;
   logic [DW-1:0] in1_data, in2_data, out_data;
   logic          in1_ready, in2_ready, req_1, req_2, out_valid, out_port, grant_err;

   always #5 clk = ~clk;

   arb_req_queue #(.DATA_W(DW), .DEPTH(DP)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in1_valid(in1_valid),
      .in1_ready(in1_ready),
      .in1_data (in1_data),
      .in2_valid(in2_valid),
      .in2_ready(in2_ready),
      .in2_data (in2_data),
      .req_1    (req_1),
      .req_2    (req_2),
      .grant_1  (grant_1),
      .grant_2  (grant_2),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_port (out_port),
      .grant_err(grant_err)
   );

   typedef struct {
      logic          v1;
      logic [DW-1:0] d1;
      logic          v2;
      logic [DW-1:0] d2;
      logic          g1;
      logic          g2;
      logic [38:0]   exp;
   } vec_t;

   vec_t          vecs[$];
   int            checks = 0;
   int            failures = 0;
   logic [DW-1:0] q1[$];
   logic [DW-1:0] q2[$];
   logic          err_m;

   // Output bundle: {in1_ready,in2_ready,req_1,req_2,out_valid,out_port,grant_err,out_data}
   function automatic logic [38:0] outs();
      return {in1_ready, in2_ready, req_1, req_2, out_valid, out_port, grant_err, out_data};
   endfunction

   function automatic vec_t mkv(logic v1, logic [DW-1:0] d1, logic v2, logic [DW-1:0] d2, logic g1, logic g2,
                                logic r1, logic r2, logic rq1, logic rq2, logic ov, logic op, logic [DW-1:0] od);
      vec_t v;
      v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2; v.g1 = g1; v.g2 = g2;
      v.exp = {r1, r2, rq1, rq2, ov, op, 1'b0, od};
      return v;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic v1, logic [DW-1:0] d1, logic v2, logic [DW-1:0] d2, logic g1, logic g2, logic ordy);
      in1_valid = v1; in1_data = d1; in2_valid = v2; in2_data = d2;
      grant_1 = g1; grant_2 = g2; out_ready = ordy;
   endtask

   // Reference: the presented entry is the granted non-empty queue head, port 1 first;
   // a handshake (presented and out_ready) removes exactly that entry.
   function automatic logic [38:0] model_exp();
      logic          s1, s2, pp1, pp2, r1, r2;
      logic [DW-1:0] d;
      s1  = grant_1 && (q1.size() > 0);
      s2  = !s1 && grant_2 && (q2.size() > 0);
      d   = s1 ? q1[0] : (s2 ? q2[0] : '0);
      pp1 = s1 && out_ready;
      pp2 = s2 && out_ready;
      r1  = (q1.size() > 1) || (q1.size() == 1 && !pp1);
      r2  = (q2.size() > 1) || (q2.size() == 1 && !pp2);
      return {q1.size() < DP, q2.size() < DP, r1, r2, s1 | s2, s2, err_m, d};
   endfunction

   task automatic model_edge();
      logic s1, s2, a1, a2;
      s1 = grant_1 && (q1.size() > 0);
      s2 = !s1 && grant_2 && (q2.size() > 0);
      a1 = in1_valid && (q1.size() < DP);
      a2 = in2_valid && (q2.size() < DP);
      if (s1 && out_ready) void'(q1.pop_front());
      if (s2 && out_ready) void'(q2.pop_front());
      if (a1) q1.push_back(in1_data);
      if (a2) q2.push_back(in2_data);
      if (grant_1 && grant_2) err_m = 1'b1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      drive(0, '0, 0, '0, 0, 0, 1);
      reset_n = 1'b0;
      q1.delete(); q2.delete(); err_m = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(0, '0, 0, '0, 0, 0, 1);
      reset_n = 1'b0;
      q1.delete(); q2.delete(); err_m = 1'b0;
      #1;
      chk("reset_outs", outs(), {1'b1, 1'b1, 5'b0, 32'h0});
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Single push with loopback grants, then fill/refuse/drain port 2.
      vecs.push_back(mkv(1, 32'hA5, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 32'h0));
      vecs.push_back(mkv(0, 0,      0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 32'h0));
      vecs.push_back(mkv(0, 0,      0, 0, 1, 0,  1, 1, 0, 0, 1, 0, 32'hA5));
      vecs.push_back(mkv(0, 0,      0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 32'h0));
      vecs.push_back(mkv(0, 0,      1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 32'h0));
      vecs.push_back(mkv(0, 0,      1, 2, 0, 0,  1, 1, 0, 1, 0, 0, 32'h0));
      vecs.push_back(mkv(0, 0,      1, 3, 0, 0,  1, 1, 0, 1, 0, 0, 32'h0));
      vecs.push_back(mkv(0, 0,      1, 4, 0, 0,  1, 1, 0, 1, 0, 0, 32'h0));
      vecs.push_back(mkv(0, 0,      1, 5, 0, 0,  1, 0, 0, 1, 0, 0, 32'h0));
      vecs.push_back(mkv(0, 0,      0, 0, 0, 1,  1, 0, 0, 1, 1, 1, 32'h1));
      vecs.push_back(mkv(0, 0,      0, 0, 0, 1,  1, 1, 0, 1, 1, 1, 32'h2));
      vecs.push_back(mkv(0, 0,      0, 0, 0, 1,  1, 1, 0, 1, 1, 1, 32'h3));
      vecs.push_back(mkv(0, 0,      0, 0, 0, 1,  1, 1, 0, 0, 1, 1, 32'h4));
      vecs.push_back(mkv(0, 0,      0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 32'h0));
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].v1, vecs[i].d1, vecs[i].v2, vecs[i].d2, vecs[i].g1, vecs[i].g2, 1);
         settle();
         chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
         step();
      end

      // out_ready stall while granted.
      reset_dut();
      drive(1, 32'hC0FFEE01, 0, '0, 0, 0, 1);
      settle(); chk("stall_push", outs(), model_exp()); step();
      drive(0, '0, 0, '0, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("stall_vld", out_valid, 1);
         chk("stall_dat", out_data, 32'hC0FFEE01);
         chk("stall_req", req_1, 1);
         step();
      end
      out_ready = 1'b1;
      settle();
      chk("stall_release_vld", out_valid, 1);
      chk("stall_release_dat", out_data, 32'hC0FFEE01);
      chk("stall_release_req", req_1, 0);
      step();
      settle();
      chk("stale_grant_vld", out_valid, 0);
      chk("stale_grant_err", grant_err, 0);
      step();

      // Double grant: port 1 wins, port 2 untouched, sticky error.
      reset_dut();
      drive(1, 32'h11, 1, 32'h22, 0, 0, 1);
      settle(); chk("dbl_push", outs(), model_exp()); step();
      drive(0, '0, 0, '0, 1, 1, 1);
      settle();
      chk("dbl_port", out_port, 0);
      chk("dbl_dat", out_data, 32'h11);
      chk("dbl_err_pre", grant_err, 0);
      step();
      drive(0, '0, 0, '0, 0, 0, 1);
      settle();
      chk("dbl_err_set", grant_err, 1);
      chk("dbl_req1", req_1, 0);
      chk("dbl_req2", req_2, 1);
      step();
      drive(0, '0, 0, '0, 0, 1, 1);
      settle();
      chk("dbl_p2_port", out_port, 1);
      chk("dbl_p2_dat", out_data, 32'h22);
      step();
      drive(0, '0, 0, '0, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         settle(); chk("dbl_err_sticky", grant_err, 1); step();
      end
      reset_dut();
      chk("dbl_err_cleared", grant_err, 0);

      // Reset mid-drain with three entries still queued.
      for (int k = 0; k < 4; k++) begin
         drive(1, 32'h100 + k, 0, '0, 0, 0, 1);
         settle(); chk("mid_fill", outs(), model_exp()); step();
      end
      drive(0, '0, 0, '0, 1, 0, 1);
      settle(); chk("mid_pop", outs(), model_exp()); step();
      settle(); chk("mid_before_rst", outs(), model_exp());
      reset_n = 1'b0;
      #1;
      chk("mid_rst_outs", outs(), {1'b1, 1'b1, 5'b0, 32'h0});
      q1.delete(); q2.delete(); err_m = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("post_rst_vld", out_valid, 0);
         chk("post_rst_req", req_1, 0);
         step();
      end

      // Random traffic against the queue model.
      reset_dut();
      for (int n = 0; n < 3000; n++) begin
         int  r;
         logic g1, g2;
         r  = $urandom_range(0, 99);
         g1 = (r < 45) || (r >= 98);
         g2 = (r >= 45 && r < 80) || (r >= 98);
         drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom, g1, g2, $urandom_range(0, 3) != 0);
         settle();
         chk("rand", outs(), model_exp());
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arb_req_queue.md
# arb_req_queue

Upstream feeder for the two-requester arbiter. Buffers transactions from two independent producers in per-port FIFOs, drives `req_1`/`req_2` into the arbiter, and consumes the returned `grant_1`/`grant_2`. On each granted cycle it pops the head of the granted queue onto a single shared output channel with valid/ready backpressure.

## Interface
- `DATA_W`, 32: payload width per transaction.
- `DEPTH`, 4: entries per port FIFO; power of two, ≥ 2.

- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in1_valid`  in  1  producer 1 has a transaction.
- `in1_ready`  out  1  port 1 FIFO can accept.
- `in1_data`  in  DATA_W  producer 1 payload.
- `in2_valid`, `in2_ready`, `in2_data`: same as port 1, for producer 2.
- `req_1`, `req_2`  out  1  request to arbiter.
- `grant_1`, `grant_2`  in  1  registered grants from arbiter.
- `out_valid`  out  1  shared output carries a transaction.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  payload of the granted head entry.
- `out_port`  out  1  0 = port 1, 1 = port 2.
- `grant_err`  out  1  sticky: both grants seen high in the same cycle.

## Operation
- Per port: FIFO with `DEPTH` entries, read/write pointers of `$clog2(DEPTH)` bits (natural wrap), count of `$clog2(DEPTH)+1` bits.
- Push: `push_x = inx_valid & inx_ready`. `inx_ready = (count_x != DEPTH)`. Strictly no push when full, even if a pop occurs in the same cycle.
- Pop: `pop_x = grant_x & (count_x != 0) & out_ready`. When both grants are high, port 1 wins: `pop_2` is forced low and `grant_err` sets.
- Simultaneous push and pop on one port: count is unchanged and both pointers advance.
- Request: `req_x = (count_x > 1) | (count_x == 1 & ~pop_x)`. Request drops in the same cycle the last entry pops, so the arbiter is not asked for a grant on an empty queue.
- Stale grant (grant high, queue empty): ignored, no output, no error.
- Output is combinational from the FIFO heads:
  - `out_valid = (grant_1 & ~empty_1) | (grant_2 & ~empty_2)`.
  - `out_port` = 0 if port 1 is granted and non-empty, otherwise 1.
  - `out_data` = head of the selected port.
- `out_valid` low → `out_port` = 0 and `out_data` = 0.
- `grant_err` clears only on reset.

## Timing
- Reset (async assert, sync release):
  - Counts, pointers and `grant_err` go to 0.
  - `req_1` = `req_2` = 0, `out_valid` = 0.
  - `in1_ready` = `in2_ready` = 1.
  - Reset mid-operation discards all buffered entries.
- Latency, with an idle arbiter and `out_ready` = 1:
  - Push at edge t → `req_x` high in cycle t+1.
  - Arbiter grant registered at edge t+1 → `out_valid` in cycle t+2.
- Throughput: one pop per granted cycle while `out_ready` is high.
- `out_ready` low: the granted head holds and `out_valid` stays asserted with stable data. No pop occurs and `req_x` stays high.
- Full: `inx_ready` low in the cycle `count_x == DEPTH`. It returns high the cycle after the first pop.
- Empty: after the last pop, `req_x` is low in that same cycle. The following cycle's grant is stale and ignored.

## Structure
- Shared package `arb_pkg`:
  - Port ID constants `PORT_1` = 1'b0, `PORT_2` = 1'b1.
  - Default `DATA_W` and `DEPTH`.
- Sub-module `req_fifo` (parameterised `DATA_W`, `DEPTH`), instantiated twice.
  - Ports: push, pop, head data, count, full, empty.
- Top level holds the request logic, pop gating, output mux and `grant_err`.

## Test plan
- Reset then single push: `in1_data` = 0xA5 at edge 0, loopback arbiter → `req_1` high at cycle 1, `out_valid` = 1 with `out_port` = 0 and `out_data` = 0xA5 at cycle 2, `req_1` low at cycle 2.
- Fill port 2 with 4 entries with no grants → `in2_ready` low after the 4th push. A 5th `in2_valid` is not accepted. Drain yields entries in order 1..4.
- Both ports loaded with 8 entries each through the real arbiter → six port-1 pops, then one port-2 pop, then the pattern repeats. No loss or duplication; per-port order is preserved.
- `out_ready` low for 3 cycles during a grant → `out_data` stable, count unchanged, `req` stays high. First pop occurs on the cycle `out_ready` returns high.
- Force `grant_1` = `grant_2` = 1 with both ports non-empty → port 1 pops, port 2 is unchanged, `grant_err` = 1 until `reset_n` is pulsed.
- Assert `reset_n` low mid-drain with 3 entries queued → all outputs reach reset values immediately. After release, counts are 0 and no `out_valid` occurs.
